// File: rtl/multi_button_debounce.sv
// multi_button_debounce: per-channel synchronize, debounce and press/release/long/repeat pulse generation
module multi_button_debounce #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 20000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES);
  localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] L_MAX = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] R_MAX = HW'(REPEAT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0] sync;
    logic [DW-1:0] dcnt, dcnt_nx;
    logic [HW-1:0] hcnt, hcnt_nx;
    state_t st, st_nx;
    logic lvl, press, rel, lng, rep;
    logic mis, acc, rise, fall, long_nx, rep_nx;
    assign btn_state[i]   = lvl;
    assign btn_press[i]   = press;
    assign btn_release[i] = rel;
    assign btn_long[i]    = lng;
    assign btn_repeat[i]  = rep;
    always_comb begin
      mis     = sync[1] != lvl;
      acc     = mis && dcnt == D_MAX;
      dcnt_nx = (!mis || acc) ? '0 : dcnt + 1'b1;
      rise    = acc && sync[1];
      fall    = acc && !sync[1];
      st_nx   = st;
      hcnt_nx = hcnt + 1'b1;
      long_nx = 1'b0;
      rep_nx  = 1'b0;
      // an accepted release wins over any long/repeat pulse due this cycle
      if (fall) begin
        st_nx   = IDLE;
        hcnt_nx = '0;
      end else if (st == IDLE) begin
        hcnt_nx = '0;
        st_nx   = rise ? PRESSED : IDLE;
      end else if (st == PRESSED && hcnt == L_MAX) begin
        long_nx = 1'b1;
        st_nx   = HELD;
        hcnt_nx = '0;
      end else if (st == HELD && hcnt == R_MAX) begin
        rep_nx  = REPEAT_EN != 0;
        hcnt_nx = '0;
      end
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync  <= '0;
        dcnt  <= '0;
        hcnt  <= '0;
        st    <= IDLE;
        lvl   <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
        lng   <= 1'b0;
        rep   <= 1'b0;
      end else begin
        sync  <= {sync[0], btn_in[i]};
        dcnt  <= dcnt_nx;
        hcnt  <= hcnt_nx;
        st    <= st_nx;
        lvl   <= acc ? sync[1] : lvl;
        press <= rise;
        rel   <= fall;
        lng   <= long_nx;
        rep   <= rep_nx;
      end
    end
  end
endmodule

// File: tb/tb_multi_button_debounce.sv
// tb_multi_button_debounce: directed checks of debounce, press/release, long and repeat timing
module tb_multi_button_debounce;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] btn_in = 4'b0;
  logic [3:0] st, pr, rl, lg, rp;
  logic [3:0] st0, pr0, rl0, lg0, rp0;
  int n_cmp = 0;
  int n_err = 0;
  int press1_cnt = 0, long2_cnt = 0, long3_cnt = 0, rep0_cnt = 0;

  always #5 clk = ~clk;

  multi_button_debounce #(.N_BTN(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20),
                          .REPEAT_CYCLES(5), .REPEAT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_state(st), .btn_press(pr),
    .btn_release(rl), .btn_long(lg), .btn_repeat(rp));

  multi_button_debounce #(.N_BTN(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20),
                          .REPEAT_CYCLES(5), .REPEAT_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_state(st0), .btn_press(pr0),
    .btn_release(rl0), .btn_long(lg0), .btn_repeat(rp0));

  always @(negedge clk) begin
    press1_cnt += int'(pr[1]);
    long2_cnt  += int'(lg[2]);
    long3_cnt  += int'(lg[3]);
    rep0_cnt   += int'(rp0[2]);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    step(3);
    chk("rst_outputs", {12'b0, st, pr, rl, lg, rp}, 32'h0);
    rst_n = 1'b1;
    step(3);
    // clean press on channel 0
    btn_in = 4'b0001;
    step(5);
    chk("c0_state_early", 32'(st), 32'h0);
    step(1);
    chk("c0_state", 32'(st), 32'h1);
    chk("c0_press", 32'(pr), 32'h1);
    chk("c0_others", {20'b0, rl, lg, rp}, 32'h0);
    step(1);
    chk("c0_press_1cyc", 32'(pr), 32'h0);
    btn_in = 4'b0000;
    step(5);
    chk("c0_rel_early", 32'(rl), 32'h0);
    step(1);
    chk("c0_release", 32'(rl), 32'h1);
    chk("c0_state_low", 32'(st), 32'h0);
    step(1);
    chk("c0_rel_1cyc", 32'(rl), 32'h0);
    // bounce on channel 1: 1,1,0,0 then stable 1
    btn_in = 4'b0010;
    step(2);
    btn_in = 4'b0000;
    step(2);
    btn_in = 4'b0010;
    step(5);
    chk("c1_bounce_hold", 32'(st), 32'h0);
    step(1);
    chk("c1_press", 32'(pr), 32'h2);
    step(2);
    chk("c1_press_count", 32'(press1_cnt), 32'd1);
    btn_in = 4'b0000;
    step(6);
    chk("c1_release", 32'(rl), 32'h2);
    step(2);
    // long hold on channel 2
    btn_in = 4'b0100;
    step(6);
    chk("c2_press", 32'(pr), 32'h4);
    step(19);
    chk("c2_long_early", 32'(lg), 32'h0);
    step(1);
    chk("c2_long", 32'(lg), 32'h4);
    chk("c2_long_noren", 32'(lg0), 32'h4);
    step(4);
    chk("c2_rep_early", 32'(rp), 32'h0);
    step(1);
    chk("c2_rep_25", 32'(rp), 32'h4);
    chk("c2_norep_25", 32'(rp0), 32'h0);
    step(1);
    chk("c2_rep_1cyc", 32'(rp), 32'h0);
    step(4);
    chk("c2_rep_30", 32'(rp), 32'h4);
    step(25);
    chk("c2_rep_55", 32'(rp), 32'h4);
    btn_in = 4'b0000;
    step(5);
    chk("c2_rep_60", 32'(rp), 32'h4);
    step(1);
    chk("c2_release", 32'(rl), 32'h4);
    chk("c2_rep_after_rel", 32'(rp), 32'h0);
    step(2);
    chk("c2_long_once", 32'(long2_cnt), 32'd1);
    chk("c2_noren_reps", 32'(rep0_cnt), 32'd0);
    // release accepted exactly when long would be due on channel 3
    btn_in = 4'b1000;
    step(6);
    chk("c3_press", 32'(pr), 32'h8);
    step(14);
    btn_in = 4'b0000;
    step(6);
    chk("c3_release_p20", 32'(rl), 32'h8);
    chk("c3_no_long_p20", 32'(lg), 32'h0);
    step(2);
    chk("c3_long_count", 32'(long3_cnt), 32'd0);
    // simultaneous presses, then reset mid-hold with buttons still down
    btn_in = 4'b1111;
    step(6);
    chk("all_press", 32'(pr), 32'hf);
    chk("all_state", 32'(st), 32'hf);
    step(3);
    rst_n = 1'b0;
    step(1);
    chk("midhold_rst", {12'b0, st, pr, rl, lg, rp}, 32'h0);
    step(2);
    chk("in_rst", {12'b0, st, pr, rl, lg, rp}, 32'h0);
    rst_n = 1'b1;
    step(1);
    chk("rst_exit", {12'b0, st, pr, rl, lg, rp}, 32'h0);
    step(4);
    chk("post_rst_early", 32'(pr), 32'h0);
    step(1);
    chk("post_rst_press", 32'(pr), 32'hf);
    chk("post_rst_norel", 32'(rl), 32'h0);
    btn_in = 4'b0000;
    step(6);
    chk("final_release", 32'(rl), 32'hf);
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multi_button_debounce.md
MULTI_BUTTON_DEBOUNCE -- requirements
Module: multi_button_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of independent button channels (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive mismatched cycles needed to accept a level change (10 ms at 100 MHz, min 2).
REQ-003 SHALL have parameter LONG_CYCLES, default 100000000, cycles from press pulse to long-press pulse (1 s, must exceed DEBOUNCE_CYCLES).
REQ-004 SHALL have parameter REPEAT_CYCLES, default 20000000, auto-repeat period after long press (min 1).
REQ-005 SHALL have parameter REPEAT_EN, default 1, 1 enables auto-repeat and 0 disables it.
REQ-006 SHALL have port clk, input, 1, system clock (100 MHz).
REQ-007 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-008 SHALL have port btn_in, input, N_BTN, raw asynchronous buttons, active-high (1 = pressed).
REQ-009 SHALL have port btn_state, output, N_BTN, debounced level per channel.
REQ-010 SHALL have port btn_press, output, N_BTN, 1-cycle pulse on accepted 0->1.
REQ-011 SHALL have port btn_release, output, N_BTN, 1-cycle pulse on accepted 1->0.
REQ-012 SHALL have port btn_long, output, N_BTN, 1-cycle pulse when a press has been held LONG_CYCLES.
REQ-013 SHALL have port btn_repeat, output, N_BTN, 1-cycle pulse every REPEAT_CYCLES after btn_long while held.

Function
REQ-014 Each channel SHALL be fully independent: own 2-FF synchronizer, debounce counter, hold counter and FSM.
REQ-015 Debounce counter width SHALL be ceil(log2(DEBOUNCE_CYCLES)); hold counter width SHALL be ceil(log2(max(LONG_CYCLES, REPEAT_CYCLES))).
REQ-016 Debounce counter SHALL clear in any cycle where synchronized input equals btn_state (a bounce restarts the count).
REQ-017 On a mismatched cycle with counter == DEBOUNCE_CYCLES-1, btn_state SHALL take the synchronized value at the next edge and the counter SHALL clear; otherwise the counter increments.
REQ-018 Latency: a clean input edge at cycle t SHALL appear on btn_state at edge t+2+DEBOUNCE_CYCLES.
REQ-019 btn_press/btn_release SHALL be registered and asserted in the same cycle btn_state changes, for exactly one cycle.
REQ-020 Per-channel FSM states SHALL be IDLE, PRESSED, HELD.
REQ-021 IDLE->PRESSED on accepted 0->1, hold counter cleared.
REQ-022 PRESSED: hold counter increments each cycle; at LONG_CYCLES-1 cycles after the press pulse, btn_long SHALL pulse (press pulse at P -> long pulse at P+LONG_CYCLES), counter clears, go to HELD.
REQ-023 HELD with REPEAT_EN=1: btn_repeat SHALL pulse at long pulse + k*REPEAT_CYCLES, k>=1, while held; with REPEAT_EN=0 btn_repeat SHALL stay 0.
REQ-024 Any accepted 1->0 in PRESSED or HELD SHALL go to IDLE; release SHALL take priority over a long/repeat pulse due in the same cycle (that pulse suppressed).
REQ-025 btn_long SHALL pulse at most once per press; a release shorter than LONG_CYCLES SHALL produce press and release only.
REQ-026 Hold counter SHALL never wrap: it clears on every state transition and on every repeat pulse.

Reset
REQ-027 While rst_n=0 at a clk edge, all synchronizer FFs, counters and outputs SHALL be 0 and every FSM IDLE.
REQ-028 A button held through reset release SHALL be treated as a new press: btn_press at 2+DEBOUNCE_CYCLES cycles after first rst_n=1 edge.
REQ-029 Reset asserted mid-debounce or mid-hold SHALL discard all progress; no pulse SHALL be emitted during or on the edge leaving reset.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, N_BTN=4)
REQ-030 Clean press on btn_in[0] at cycle 10 -> btn_state[0]=1 and btn_press[0] pulse at cycle 16; other channels stay 0.
REQ-031 Bounce 1,0,1 with 2-cycle pulses on btn_in[1] then stable 1 -> exactly one btn_press[1], only after 4 consecutive synchronized 1s.
REQ-032 Hold btn_in[2] 60 cycles after press pulse at P -> btn_long[2] at P+20, btn_repeat[2] at P+25, P+30, ..., release pulse after input falls; with REPEAT_EN=0 no repeat pulses.
REQ-033 Release timed so accepted 1->0 lands on P+20 -> btn_release pulse, no btn_long.
REQ-034 Simultaneous presses on all 4 channels -> 4 press pulses in the same cycle; reset asserted mid-hold -> all outputs 0 next edge, no release pulse.
REQ-035 Button held during reset, rst_n rises at cycle R -> btn_press at R+6.
